// File: rtl/weight_loader_pkg.sv
// Shared types, default geometry and helpers for the weight buffer loader.
package weight_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_STREAM,
        ST_DRAIN,
        ST_FIN
    } state_t;

    localparam int unsigned DEF_DATA_LEN   = 64;
    localparam int unsigned DEF_DDR_WIDTH  = 256;
    localparam int unsigned DEF_BUFFER_NUM = 32;
    localparam int unsigned LANES          = DEF_DDR_WIDTH / DEF_DATA_LEN;
    localparam int unsigned GROUPS         = DEF_BUFFER_NUM / LANES;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/weight_buffer_loader_addr_gen.sv
// Write address / bank-group sequencer: k (inner), w, g (outer) counters,
// incremental buffer address and the one-hot group write-enable mask.
module weight_addr_gen
    import weight_loader_pkg::*;
#(
    parameter int unsigned ADDR_LEN   = 16,
    parameter int unsigned SINGLE_LEN = 24,
    parameter int unsigned KW_LEN     = 5,
    parameter int unsigned BUFFER_NUM = 32,
    parameter int unsigned LANES      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_LEN-1:0]   st_addr,
    input  logic [SINGLE_LEN-1:0] weight_num,
    input  logic [KW_LEN-1:0]     kernel_words,
    input  logic                  step,
    output logic [ADDR_LEN-1:0]   addr,
    output logic [BUFFER_NUM-1:0] wea_c
);

    localparam int unsigned N_GROUPS = BUFFER_NUM / LANES;
    localparam int unsigned G_W      = (clog2(N_GROUPS) == 0) ? 1 : clog2(N_GROUPS);

    logic [ADDR_LEN-1:0]   st_q;
    logic [SINGLE_LEN-1:0] wn_q;
    logic [SINGLE_LEN-1:0] w_q;
    logic [KW_LEN-1:0]     kw_q;
    logic [KW_LEN-1:0]     k_q;
    logic [G_W-1:0]        g_q;
    logic                  k_last;
    logic                  w_last;

    assign k_last = (k_q == kw_q - KW_LEN'(1));
    assign w_last = (w_q == wn_q - SINGLE_LEN'(1));

    // Address only ever adds one or reloads the start, so no multiplier is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q <= '0;
            wn_q <= '0;
            kw_q <= '0;
            k_q  <= '0;
            w_q  <= '0;
            g_q  <= '0;
            addr <= '0;
        end else if (load) begin
            st_q <= st_addr;
            wn_q <= weight_num;
            kw_q <= kernel_words;
            k_q  <= '0;
            w_q  <= '0;
            g_q  <= '0;
            addr <= st_addr;
        end else if (step) begin
            if (!k_last) begin
                k_q  <= k_q + KW_LEN'(1);
                addr <= addr + ADDR_LEN'(1);
            end else if (!w_last) begin
                k_q  <= '0;
                w_q  <= w_q + SINGLE_LEN'(1);
                addr <= addr + ADDR_LEN'(1);
            end else begin
                k_q  <= '0;
                w_q  <= '0;
                g_q  <= g_q + G_W'(1);
                addr <= st_q;
            end
        end
    end

    always_comb begin
        wea_c = '0;
        for (int i = 0; i < int'(BUFFER_NUM); i++) begin
            wea_c[i] = (G_W'(i / int'(LANES)) == g_q);
        end
    end

endmodule

// File: rtl/weight_buffer_loader.sv
// Streams one layer of weights from the DDR read FIFO into the banked weight buffer.
// Optional WEIGHT_LOADER_PINGPONG_EN: alternate buffer halves per load via bank_sel.
module weight_buffer_loader
    import weight_loader_pkg::*;
#(
    parameter int unsigned DATA_LEN     = DEF_DATA_LEN,
    parameter int unsigned DDR_WIDTH    = DEF_DDR_WIDTH,
    parameter int unsigned BUFFER_NUM   = DEF_BUFFER_NUM,
    parameter int unsigned ADDR_LEN     = 16,
    parameter int unsigned DDR_ADDR_LEN = 32,
    parameter int unsigned SINGLE_LEN   = 24,
    parameter int unsigned KW_LEN       = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    conf,
    input  logic [SINGLE_LEN-1:0]   weight_num,
    input  logic [KW_LEN-1:0]       kernel_words,
    input  logic [DDR_ADDR_LEN-1:0] ddr_st_addr,
    input  logic [ADDR_LEN-1:0]     wb_st_addr,
    output logic [DDR_ADDR_LEN-1:0] ddr_st_addr_out,
    output logic [SINGLE_LEN-1:0]   ddr_len,
    output logic                    ddr_conf,
    input  logic                    ddr_fifo_empty,
    output logic                    ddr_fifo_req,
    input  logic [DDR_WIDTH-1:0]    ddr_fifo_data,
    output logic [ADDR_LEN-1:0]     wb_addr,
    output logic [DDR_WIDTH-1:0]    wb_data,
    output logic [BUFFER_NUM-1:0]   wb_wea,
    output logic                    done,
`ifdef WEIGHT_LOADER_PINGPONG_EN
    output logic                    bank_sel,
`endif
    output logic                    idle
);

    localparam int unsigned N_LANES  = DDR_WIDTH / DATA_LEN;
    localparam int unsigned N_GROUPS = BUFFER_NUM / N_LANES;
    localparam int unsigned TB_W     = SINGLE_LEN + KW_LEN + clog2(N_GROUPS) + 1;

    state_t              state_q;
    state_t              state_d;
    logic                load_c;
    logic                req_c;
    logic                pend_q;
    logic [TB_W-1:0]     total_c;
    logic [TB_W-1:0]     total_q;
    logic [TB_W-1:0]     issued_q;
    logic [SINGLE_LEN-1:0] ddr_len_c;
    logic [ADDR_LEN-1:0]   gen_addr;
    logic [BUFFER_NUM-1:0] gen_wea;

    assign total_c   = TB_W'(weight_num) * TB_W'(kernel_words) * TB_W'(N_GROUPS);
    assign ddr_len_c = SINGLE_LEN'(total_c * TB_W'(DDR_WIDTH / 8));
    assign ddr_fifo_req = req_c;

    // An empty load still passes through DRAIN so done keeps a fixed latency.
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        req_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (conf) begin
                    load_c  = 1'b1;
                    state_d = (total_c == '0) ? ST_DRAIN : ST_CMD;
                end
            end
            ST_CMD: state_d = ST_STREAM;
            ST_STREAM: begin
                req_c = !ddr_fifo_empty && (issued_q < total_q);
                if (req_c && (issued_q == total_q - TB_W'(1))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_FIN;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            total_q         <= '0;
            issued_q        <= '0;
            pend_q          <= 1'b0;
            ddr_st_addr_out <= '0;
            ddr_len         <= '0;
            ddr_conf        <= 1'b0;
            wb_addr         <= '0;
            wb_data         <= '0;
            wb_wea          <= '0;
            done            <= 1'b0;
            idle            <= 1'b1;
`ifdef WEIGHT_LOADER_PINGPONG_EN
            bank_sel        <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ddr_conf <= (state_d == ST_CMD);
            done     <= (state_d == ST_FIN);
            idle     <= (state_d == ST_IDLE);
            if (load_c) begin
                total_q         <= total_c;
                issued_q        <= '0;
                ddr_len         <= ddr_len_c;
                ddr_st_addr_out <= ddr_st_addr;
            end else if (req_c) begin
                issued_q <= issued_q + TB_W'(1);
            end
            // Data lands one cycle after the accepted request; write it the cycle after.
            pend_q <= req_c;
            wb_wea <= pend_q ? gen_wea : '0;
            if (pend_q) begin
                wb_data <= ddr_fifo_data;
`ifdef WEIGHT_LOADER_PINGPONG_EN
                wb_addr <= {bank_sel, gen_addr[ADDR_LEN-2:0]};
`else
                wb_addr <= gen_addr;
`endif
            end
`ifdef WEIGHT_LOADER_PINGPONG_EN
            if (state_q == ST_DRAIN) begin
                bank_sel <= ~bank_sel;
            end
`endif
        end
    end

    weight_addr_gen #(
        .ADDR_LEN   (ADDR_LEN),
        .SINGLE_LEN (SINGLE_LEN),
        .KW_LEN     (KW_LEN),
        .BUFFER_NUM (BUFFER_NUM),
        .LANES      (N_LANES)
    ) u_addr_gen (
        .clk          (clk),
        .rst          (rst),
        .load         (load_c),
        .st_addr      (wb_st_addr),
        .weight_num   (weight_num),
        .kernel_words (kernel_words),
        .step         (pend_q),
        .addr         (gen_addr),
        .wea_c        (gen_wea)
    );

endmodule

// File: tb/tb_weight_buffer_loader.sv
// Scoreboard bench for weight_buffer_loader at the default 256-bit / 32-bank geometry.
module tb_weight_buffer_loader;
    import weight_loader_pkg::*;

    typedef struct {
        logic [15:0]  addr;
        logic [31:0]  wea;
        logic [255:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         conf;
    logic [23:0]  weight_num;
    logic [4:0]   kernel_words;
    logic [31:0]  ddr_st_addr;
    logic [15:0]  wb_st_addr;
    logic [31:0]  ddr_st_addr_out;
    logic [23:0]  ddr_len;
    logic         ddr_conf;
    logic         ddr_fifo_empty;
    logic         ddr_fifo_req;
    logic [255:0] ddr_fifo_data;
    logic [15:0]  wb_addr;
    logic [255:0] wb_data;
    logic [31:0]  wb_wea;
    logic         done;
    logic         idle;
`ifdef WEIGHT_LOADER_PINGPONG_EN
    logic         bank_sel;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int accepted = 0;
    int last_req_cyc = 0;
    int beat_n = 0;
    int done_cnt = 0;
    int conf_pulses = 0;
    int conf_cyc = 0;
    bit acc_d1 = 0;
    bit acc_d2 = 0;
    bit rand_empty = 0;
    bit bank_model = 0;
    exp_t sb[$];

    weight_buffer_loader dut (
        .clk             (clk),
        .rst             (rst),
        .conf            (conf),
        .weight_num      (weight_num),
        .kernel_words    (kernel_words),
        .ddr_st_addr     (ddr_st_addr),
        .wb_st_addr      (wb_st_addr),
        .ddr_st_addr_out (ddr_st_addr_out),
        .ddr_len         (ddr_len),
        .ddr_conf        (ddr_conf),
        .ddr_fifo_empty  (ddr_fifo_empty),
        .ddr_fifo_req    (ddr_fifo_req),
        .ddr_fifo_data   (ddr_fifo_data),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .wb_wea          (wb_wea),
        .done            (done),
`ifdef WEIGHT_LOADER_PINGPONG_EN
        .bank_sel        (bank_sel),
`endif
        .idle            (idle)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] pat(input int b);
        logic [255:0] p;
        for (int i = 0; i < 8; i++) p[i*32 +: 32] = 32'hA500_0000 ^ (32'(b) << 8) ^ 32'(i);
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // FIFO model: data for an accepted request appears in the next cycle.
    always @(posedge clk) begin
        bit acc_now;
        acc_now = 0;
        if (rst) begin
            acc_d1 = 0;
            acc_d2 = 0;
        end else begin
            if (ddr_fifo_req && !ddr_fifo_empty) begin
                accepted++;
                last_req_cyc = cyc;
                ddr_fifo_data <= pat(beat_n);
                beat_n++;
                acc_now = 1;
            end
            acc_d2 = acc_d1;
            acc_d1 = acc_now;
        end
        cyc++;
    end

    always @(negedge clk) if (rand_empty) ddr_fifo_empty = 1'($urandom_range(0, 1));

    // Monitor: every write must sit exactly two cycles after an accepted request.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ((wb_wea != 0) || acc_d2)) chk("wr_slot", 64'(wb_wea != 0), 64'(acc_d2));
        if (wb_wea != 0) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write addr=%0h wea=%0h", wb_addr, wb_wea);
            end else begin
                e = sb.pop_front();
                if (wb_addr !== e.addr || wb_wea !== e.wea || wb_data !== e.data) begin
                    bad++;
                    $display("FAIL write act addr=%0h wea=%0h data=%0h exp addr=%0h wea=%0h data=%0h",
                             wb_addr, wb_wea, wb_data, e.addr, e.wea, e.data);
                end
            end
        end
        if (ddr_conf) conf_pulses++;
        if (done) begin
            done_cnt++;
            bank_model = ~bank_model;
        end
    end

    task automatic start_load(input int wn, input int kw, input logic [15:0] st, input logic [31:0] da);
        exp_t e;
        int b;
        @(negedge clk);
        weight_num   = 24'(wn);
        kernel_words = 5'(kw);
        wb_st_addr   = st;
        ddr_st_addr  = da;
        conf         = 1'b1;
        conf_cyc     = cyc;
        beat_n       = 0;
        b = 0;
        for (int g = 0; g < int'(GROUPS); g++)
            for (int w = 0; w < wn; w++)
                for (int k = 0; k < kw; k++) begin
                    e.addr = st + 16'(w * kw + k);
`ifdef WEIGHT_LOADER_PINGPONG_EN
                    e.addr[15] = bank_model;
`endif
                    e.wea  = 32'hF << (4 * g);
                    e.data = pat(b);
                    b++;
                    sb.push_back(e);
                end
        @(negedge clk);
        conf = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dc);
        bit found;
        found = 0;
        dc = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1;
                dc = cyc;
            end
        end
        if (!found) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int dc;
        int a0;
        int c0;
        int d0;
        rst = 1'b1; conf = 1'b0; weight_num = '0; kernel_words = '0;
        ddr_st_addr = '0; wb_st_addr = '0; ddr_fifo_empty = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_idle", 64'(idle), 1);
        chk("rst_done", 64'(done), 0);
        chk("rst_wea", 64'(wb_wea), 0);
        chk("rst_req", 64'(ddr_fifo_req), 0);
        chk("rst_ddr_conf", 64'(ddr_conf), 0);
        chk("rst_len", 64'(ddr_len), 0);
        rst = 1'b0;
        ddr_fifo_empty = 1'b0;

        // 3x3 layer, FIFO always full
        a0 = accepted; c0 = conf_pulses;
        start_load(2, 9, 16'h0010, 32'h8000_0000);
        chk("a_len", 64'(ddr_len), 4608);
        chk("a_ddr_conf", 64'(ddr_conf), 1);
        chk("a_ddr_addr", 64'(ddr_st_addr_out), 64'h8000_0000);
        chk("a_idle", 64'(idle), 0);
        wait_done(400, dc);
        chk("a_done_lat", 64'(dc - last_req_cyc), 2);
        chk("a_beats", 64'(accepted - a0), 144);
        chk("a_conf_pulses", 64'(conf_pulses - c0), 1);
        // conf in the done cycle must be ignored; the next cycle's conf starts 1x1
        weight_num = 24'd7; kernel_words = 5'd3; wb_st_addr = 16'h0555; conf = 1'b1;
        a0 = accepted;
        start_load(5, 1, 16'h0100, 32'h9000_0000);
        chk("b_len", 64'(ddr_len), 1280);
        wait_done(200, dc);
        chk("b_done_lat", 64'(dc - last_req_cyc), 2);
        repeat (2) @(negedge clk);
        chk("b_beats", 64'(accepted - a0), 40);
        chk("b_done_cnt", 64'(done_cnt), 2);
        chk("b_sb_empty", 64'(sb.size()), 0);

        // random FIFO stalls, start address near the top to exercise wrap
        a0 = accepted;
        rand_empty = 1;
        start_load(2, 9, 16'hFFF8, 32'h0000_1000);
        wait_done(2000, dc);
        rand_empty = 0;
        ddr_fifo_empty = 1'b0;
        chk("c_done_lat", 64'(dc - last_req_cyc), 2);
        repeat (2) @(negedge clk);
        chk("c_beats", 64'(accepted - a0), 144);
        chk("c_sb_empty", 64'(sb.size()), 0);

        // conf mid-stream with different inputs is ignored
        a0 = accepted;
        start_load(3, 2, 16'h0200, 32'h9000_0000);
        repeat (10) @(negedge clk);
        weight_num = 24'd9; kernel_words = 5'd3; wb_st_addr = 16'h0555;
        ddr_st_addr = 32'hDEAD_0000; conf = 1'b1;
        @(negedge clk);
        conf = 1'b0;
        chk("d_len", 64'(ddr_len), 1536);
        chk("d_ddr_addr", 64'(ddr_st_addr_out), 64'h9000_0000);
        wait_done(300, dc);
        repeat (2) @(negedge clk);
        chk("d_beats", 64'(accepted - a0), 48);
        chk("d_sb_empty", 64'(sb.size()), 0);

        // zero weights: no command, no request, done two cycles after conf
        a0 = accepted; c0 = conf_pulses;
        start_load(0, 9, 16'h0300, 32'h0000_2000);
        chk("e_ddr_conf", 64'(ddr_conf), 0);
        chk("e_len", 64'(ddr_len), 0);
        wait_done(10, dc);
        chk("e_done_lat", 64'(dc - conf_cyc), 2);
        repeat (2) @(negedge clk);
        chk("e_beats", 64'(accepted - a0), 0);
        chk("e_conf_pulses", 64'(conf_pulses - c0), 0);

        // asynchronous reset mid-stream
        start_load(4, 9, 16'h0040, 32'h0000_3000);
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("f_idle", 64'(idle), 1);
        chk("f_wea", 64'(wb_wea), 0);
        chk("f_req", 64'(ddr_fifo_req), 0);
        chk("f_addr", 64'(wb_addr), 0);
        chk("f_len", 64'(ddr_len), 0);
        sb.delete();
        bank_model = 0;
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("f_no_done", 64'(done_cnt), 64'(d0));
        a0 = accepted;
        start_load(1, 3, 16'h0700, 32'h0000_4000);
        wait_done(200, dc);
        chk("f_done_lat", 64'(dc - last_req_cyc), 2);
        repeat (2) @(negedge clk);
        chk("f_beats", 64'(accepted - a0), 24);
        chk("f_sb_empty", 64'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
